// File: rtl/conv_pkg.sv
// Shared definitions for the conv operand stage: default geometry, mode
// encodings and the lane-slicing helper used by the masking logic.
package conv_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_IFM_LANES = 45;
    localparam int DEF_C1_LANES  = 13;
    localparam int DEF_W_LANES   = 9;
    localparam int DEF_REUSE_W   = 9;

    localparam logic MODE_CONV3 = 1'b0;
    localparam logic MODE_CONV1 = 1'b1;

    // Bit offset of a lane inside a flattened lane vector.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/conv_operand_stage_if.sv
// Operand-stage bus: weight load, IFM stream, operand output and status.
// master = producer/consumer side around the stage, slave = the stage itself.
interface conv_operand_stage_if #(
    parameter int DATA_W    = conv_pkg::DEF_DATA_W,
    parameter int IFM_LANES = conv_pkg::DEF_IFM_LANES,
    parameter int W_LANES   = conv_pkg::DEF_W_LANES,
    parameter int REUSE_W   = conv_pkg::DEF_REUSE_W
) ();

    // Every channel transfers on the rising edge where valid && ready.
    // valid never depends on ready; only op_ready feeds ifm_ready combinationally.
    logic                          cfg_mode;
    logic [REUSE_W-1:0]            cfg_reuse;

    logic                          w_valid;
    logic                          w_ready;
    logic [W_LANES*DATA_W-1:0]     w_data;

    logic                          ifm_valid;
    logic                          ifm_ready;
    logic [IFM_LANES*DATA_W-1:0]   ifm_data;
    logic                          ifm_last;

    logic                          op_valid;
    logic                          op_ready;
    logic [IFM_LANES*DATA_W-1:0]   op_ifm;
    logic [W_LANES*DATA_W-1:0]     op_weight;
    logic                          op_mode;
    logic                          op_last;

    logic                          act_valid;
    logic                          shd_valid;

    modport master (
        output cfg_mode, cfg_reuse,
        output w_valid, w_data,
        output ifm_valid, ifm_data, ifm_last,
        output op_ready,
        input  w_ready, ifm_ready,
        input  op_valid, op_ifm, op_weight, op_mode, op_last,
        input  act_valid, shd_valid
    );

    modport slave (
        input  cfg_mode, cfg_reuse,
        input  w_valid, w_data,
        input  ifm_valid, ifm_data, ifm_last,
        input  op_ready,
        output w_ready, ifm_ready,
        output op_valid, op_ifm, op_weight, op_mode, op_last,
        output act_valid, shd_valid
    );

endinterface

// File: rtl/weight_bank_db.sv
// Double-buffered weight bank: an active set feeding the PEs and a shadow set
// prefetched behind it, promoted to active in the same cycle the active releases.
module weight_bank_db
    import conv_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int W_LANES = DEF_W_LANES,
    parameter int REUSE_W = DEF_REUSE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_valid_i,
    input  logic [W_LANES*DATA_W-1:0] w_data_i,
    input  logic                      cfg_mode_i,
    input  logic [REUSE_W-1:0]        cfg_reuse_i,
    input  logic                      release_i,
    output logic                      w_ready_o,
    output logic                      act_valid_o,
    output logic                      shd_valid_o,
    output logic [W_LANES*DATA_W-1:0] act_data_o,
    output logic                      act_mode_o,
    output logic [REUSE_W-1:0]        act_reuse_o
);

    localparam int W_BITS = W_LANES * DATA_W;

    logic              act_valid_q, act_valid_d;
    logic [W_BITS-1:0] act_data_q,  act_data_d;
    logic              act_mode_q,  act_mode_d;
    logic [REUSE_W-1:0] act_reuse_q, act_reuse_d;

    logic              shd_valid_q, shd_valid_d;
    logic [W_BITS-1:0] shd_data_q,  shd_data_d;
    logic              shd_mode_q,  shd_mode_d;
    logic [REUSE_W-1:0] shd_reuse_q, shd_reuse_d;

    logic               w_fire;
    logic               load_act;
    logic [REUSE_W-1:0] reuse_norm;

    assign w_ready_o  = !rst && !shd_valid_q;
    assign w_fire     = w_valid_i && w_ready_o;
    // A set lands in active when active is empty or is vacating with no shadow
    // behind it (w_fire already implies the shadow is empty).
    assign load_act   = w_fire && (!act_valid_q || release_i);
    assign reuse_norm = (cfg_reuse_i == '0) ? REUSE_W'(1) : cfg_reuse_i;

    always_comb begin
        act_valid_d = act_valid_q;
        act_data_d  = act_data_q;
        act_mode_d  = act_mode_q;
        act_reuse_d = act_reuse_q;
        shd_valid_d = shd_valid_q;
        shd_data_d  = shd_data_q;
        shd_mode_d  = shd_mode_q;
        shd_reuse_d = shd_reuse_q;

        if (release_i && shd_valid_q) begin
            act_data_d  = shd_data_q;
            act_mode_d  = shd_mode_q;
            act_reuse_d = shd_reuse_q;
            shd_valid_d = 1'b0;
        end else if (load_act) begin
            act_valid_d = 1'b1;
            act_data_d  = w_data_i;
            act_mode_d  = cfg_mode_i;
            act_reuse_d = reuse_norm;
        end else if (release_i) begin
            act_valid_d = 1'b0;
        end

        if (w_fire && !load_act) begin
            shd_valid_d = 1'b1;
            shd_data_d  = w_data_i;
            shd_mode_d  = cfg_mode_i;
            shd_reuse_d = reuse_norm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_valid_q <= 1'b0;
            act_data_q  <= '0;
            act_mode_q  <= MODE_CONV3;
            act_reuse_q <= '0;
            shd_valid_q <= 1'b0;
            shd_data_q  <= '0;
            shd_mode_q  <= MODE_CONV3;
            shd_reuse_q <= '0;
        end else begin
            act_valid_q <= act_valid_d;
            act_data_q  <= act_data_d;
            act_mode_q  <= act_mode_d;
            act_reuse_q <= act_reuse_d;
            shd_valid_q <= shd_valid_d;
            shd_data_q  <= shd_data_d;
            shd_mode_q  <= shd_mode_d;
            shd_reuse_q <= shd_reuse_d;
        end
    end

    assign act_valid_o = act_valid_q;
    assign shd_valid_o = shd_valid_q;
    assign act_data_o  = act_data_q;
    assign act_mode_o  = act_mode_q;
    assign act_reuse_o = act_reuse_q;

endmodule

// File: rtl/conv_operand_stage.sv
// Conv operand register stage: pairs each IFM beat with the active weight set,
// masks lanes for conv1, and counts beats to release weight sets.
module conv_operand_stage
    import conv_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int IFM_LANES = DEF_IFM_LANES,
    parameter int C1_LANES  = DEF_C1_LANES,
    parameter int W_LANES   = DEF_W_LANES,
    parameter int REUSE_W   = DEF_REUSE_W
) (
    input logic                 clk,
    input logic                 rst,
    conv_operand_stage_if.slave bus
);

    localparam int IFM_BITS = IFM_LANES * DATA_W;
    localparam int W_BITS   = W_LANES * DATA_W;

    logic                act_valid;
    logic                shd_valid;
    logic                w_ready;
    logic [W_BITS-1:0]   act_data;
    logic                act_mode;
    logic [REUSE_W-1:0]  act_reuse;

    logic                ifm_ready;
    logic                ifm_fire;
    logic                release_act;

    logic [REUSE_W-1:0]  use_cnt_q, use_cnt_d;

    logic                op_valid_q,  op_valid_d;
    logic [IFM_BITS-1:0] op_ifm_q,    op_ifm_d;
    logic [W_BITS-1:0]   op_weight_q, op_weight_d;
    logic                op_mode_q,   op_mode_d;
    logic                op_last_q,   op_last_d;

    logic [IFM_BITS-1:0] ifm_masked;
    logic [W_BITS-1:0]   w_masked;

    weight_bank_db #(
        .DATA_W  (DATA_W),
        .W_LANES (W_LANES),
        .REUSE_W (REUSE_W)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .w_valid_i   (bus.w_valid),
        .w_data_i    (bus.w_data),
        .cfg_mode_i  (bus.cfg_mode),
        .cfg_reuse_i (bus.cfg_reuse),
        .release_i   (release_act),
        .w_ready_o   (w_ready),
        .act_valid_o (act_valid),
        .shd_valid_o (shd_valid),
        .act_data_o  (act_data),
        .act_mode_o  (act_mode),
        .act_reuse_o (act_reuse)
    );

    assign ifm_ready   = !rst && act_valid && (!op_valid_q || bus.op_ready);
    assign ifm_fire    = bus.ifm_valid && ifm_ready;
    // Stored reuse is never 0, so reuse-1 cannot wrap.
    assign release_act = ifm_fire && ((use_cnt_q == act_reuse - 1'b1) || bus.ifm_last);

    always_comb begin
        use_cnt_d = use_cnt_q;
        if (ifm_fire) begin
            use_cnt_d = release_act ? '0 : use_cnt_q + 1'b1;
        end
    end

    always_comb begin
        ifm_masked = bus.ifm_data;
        w_masked   = act_data;
        if (act_mode == MODE_CONV1) begin
            for (int l = C1_LANES; l < IFM_LANES; l++) begin
                ifm_masked[lane_lsb(l, DATA_W) +: DATA_W] = '0;
            end
            for (int l = 1; l < W_LANES; l++) begin
                w_masked[lane_lsb(l, DATA_W) +: DATA_W] = '0;
            end
        end
    end

    always_comb begin
        op_valid_d  = op_valid_q;
        op_ifm_d    = op_ifm_q;
        op_weight_d = op_weight_q;
        op_mode_d   = op_mode_q;
        op_last_d   = op_last_q;
        if (ifm_fire) begin
            op_valid_d  = 1'b1;
            op_ifm_d    = ifm_masked;
            op_weight_d = w_masked;
            op_mode_d   = act_mode;
            op_last_d   = bus.ifm_last;
        end else if (bus.op_ready) begin
            op_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            use_cnt_q   <= '0;
            op_valid_q  <= 1'b0;
            op_ifm_q    <= '0;
            op_weight_q <= '0;
            op_mode_q   <= MODE_CONV3;
            op_last_q   <= 1'b0;
        end else begin
            use_cnt_q   <= use_cnt_d;
            op_valid_q  <= op_valid_d;
            op_ifm_q    <= op_ifm_d;
            op_weight_q <= op_weight_d;
            op_mode_q   <= op_mode_d;
            op_last_q   <= op_last_d;
        end
    end

    assign bus.w_ready   = w_ready;
    assign bus.ifm_ready = ifm_ready;
    assign bus.op_valid  = op_valid_q && !rst;
    assign bus.op_ifm    = op_ifm_q;
    assign bus.op_weight = op_weight_q;
    assign bus.op_mode   = op_mode_q;
    assign bus.op_last   = op_last_q;
    assign bus.act_valid = act_valid;
    assign bus.shd_valid = shd_valid;

endmodule

// File: tb/tb_conv_operand_stage.sv
// Bench for conv_operand_stage: directed scenarios plus random traffic, all
// checked against a queue-of-weight-sets reference model.
module tb_conv_operand_stage;
    import conv_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int IL = DEF_IFM_LANES;
    localparam int CL = DEF_C1_LANES;
    localparam int WL = DEF_W_LANES;
    localparam int RW = DEF_REUSE_W;
    localparam int IB = IL * DW;
    localparam int WB = WL * DW;

    localparam logic [IB-1:0] C1_MASK = {IB{1'b1}} >> ((IL - CL) * DW);
    localparam logic [WB-1:0] W0_MASK = {{(WB - DW){1'b0}}, {DW{1'b1}}};

    typedef struct {
        logic [WB-1:0] data;
        logic          mode;
        int            reuse;
    } wset_t;

    typedef struct packed {
        logic [IB-1:0] ifm;
        logic [WB-1:0] wt;
        logic          mode;
        logic          last;
    } op_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_operand_stage_if #(.DATA_W(DW), .IFM_LANES(IL), .W_LANES(WL), .REUSE_W(RW)) bus ();

    conv_operand_stage #(
        .DATA_W(DW), .IFM_LANES(IL), .C1_LANES(CL), .W_LANES(WL), .REUSE_W(RW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    wset_t wq[$];
    op_t   exp_q[$];
    int    used = 0;

    always @(posedge clk) begin
        if (rst) begin
            wq.delete();
            exp_q.delete();
            used = 0;
        end else begin
            if (bus.op_valid && bus.op_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (bus.ifm_valid && bus.ifm_ready) begin
                check_eq("ifm_set_avail", wq.size() > 0, 1'b1);
                if (wq.size() > 0) begin
                    op_t o;
                    o.ifm  = wq[0].mode ? (bus.ifm_data & C1_MASK) : bus.ifm_data;
                    o.wt   = wq[0].mode ? (wq[0].data & W0_MASK) : wq[0].data;
                    o.mode = wq[0].mode;
                    o.last = bus.ifm_last;
                    exp_q.push_back(o);
                    used++;
                    if (used >= wq[0].reuse || bus.ifm_last) begin
                        void'(wq.pop_front());
                        used = 0;
                    end
                end
            end
            if (bus.w_valid && bus.w_ready) begin
                wset_t s;
                s.data  = bus.w_data;
                s.mode  = bus.cfg_mode;
                s.reuse = (bus.cfg_reuse == 0) ? 1 : int'(bus.cfg_reuse);
                wq.push_back(s);
            end
        end
    end

    // Per-cycle scoreboard, sampled mid-cycle after outputs settle.
    always @(posedge clk) begin
        #4;
        check_eq("w_ready",   bus.w_ready,   !rst && wq.size() < 2);
        check_eq("act_valid", bus.act_valid, wq.size() >= 1);
        check_eq("shd_valid", bus.shd_valid, wq.size() >= 2);
        check_eq("op_valid",  bus.op_valid,  !rst && exp_q.size() > 0);
        check_eq("ifm_ready", bus.ifm_ready,
                 !rst && wq.size() > 0 && (exp_q.size() == 0 || bus.op_ready));
        if (bus.op_valid && exp_q.size() > 0) begin
            check_eq("op_ifm",    bus.op_ifm,    exp_q[0].ifm);
            check_eq("op_weight", bus.op_weight, exp_q[0].wt);
            check_eq("op_mode",   bus.op_mode,   exp_q[0].mode);
            check_eq("op_last",   bus.op_last,   exp_q[0].last);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [IB-1:0] rand_ifm();
        logic [IB-1:0] v;
        for (int l = 0; l < IL; l++) v[l*DW +: DW] = DW'($urandom_range(0, 65535));
        return v;
    endfunction

    function automatic logic [WB-1:0] rand_w();
        logic [WB-1:0] v;
        for (int l = 0; l < WL; l++) v[l*DW +: DW] = DW'($urandom_range(0, 65535));
        return v;
    endfunction

    task automatic load_w(input logic mode, input int reuse, input logic [WB-1:0] data);
        bus.w_valid   = 1'b1;
        bus.cfg_mode  = mode;
        bus.cfg_reuse = RW'(reuse);
        bus.w_data    = data;
        for (int n = 0; n < 50 && !bus.w_ready; n++) @(negedge clk);
        check_eq("w_accept", bus.w_ready, 1'b1);
        @(negedge clk);
        bus.w_valid = 1'b0;
    endtask

    task automatic send_ifm(input logic [IB-1:0] data, input logic last);
        bus.ifm_valid = 1'b1;
        bus.ifm_data  = data;
        bus.ifm_last  = last;
        #1;
        for (int n = 0; n < 50 && !bus.ifm_ready; n++) begin
            @(negedge clk);
            #1;
        end
        check_eq("ifm_accept", bus.ifm_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.ifm_valid = 1'b0;
        bus.ifm_last  = 1'b0;
        bus.w_valid   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WB-1:0] wa, wb, wc, wd, we;
        logic [IB-1:0] snap_ifm, exp_c1;
        logic [WB-1:0] snap_w;

        bus.cfg_mode  = MODE_CONV3;
        bus.cfg_reuse = '0;
        bus.w_valid   = 1'b0;
        bus.w_data    = '0;
        bus.ifm_valid = 1'b0;
        bus.ifm_data  = '0;
        bus.ifm_last  = 1'b0;
        bus.op_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check_eq("rst_op_ifm",    bus.op_ifm,    '0);
        check_eq("rst_op_weight", bus.op_weight, '0);
        check_eq("rst_op_last",   bus.op_last,   1'b0);
        rst = 1'b0;
        @(negedge clk);

        // reuse / swap: A reuse=4, B reuse=2, six back-to-back beats
        wa = rand_w();
        wb = rand_w();
        load_w(MODE_CONV3, 4, wa);
        load_w(MODE_CONV3, 2, wb);
        check_eq("swap_w_ready_full", bus.w_ready, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send_ifm(rand_ifm(), 1'b0);
            check_eq("swap_no_gap", bus.op_valid, 1'b1);
            check_eq("swap_weight", bus.op_weight, (i < 4) ? wa : wb);
            if (i < 3) check_eq("swap_w_ready", bus.w_ready, 1'b0);
        end
        idle(2);

        // conv1 masking
        for (int l = 0; l < WL; l++) wc[l*DW +: DW] = 16'h1234;
        load_w(MODE_CONV1, 1, wc);
        for (int l = 0; l < IL; l++) snap_ifm[l*DW +: DW] = 16'hABCD;
        exp_c1 = '0;
        for (int l = 0; l < CL; l++) exp_c1[l*DW +: DW] = 16'hABCD;
        send_ifm(snap_ifm, 1'b0);
        check_eq("c1_ifm",    bus.op_ifm,    exp_c1);
        check_eq("c1_weight", bus.op_weight, {{(WB - DW){1'b0}}, 16'h1234});
        check_eq("c1_mode",   bus.op_mode,   1'b1);
        idle(2);

        // ifm_last early release, then release with no shadow
        wc = rand_w();
        wd = rand_w();
        we = rand_w();
        load_w(MODE_CONV3, 10, wc);
        load_w(MODE_CONV3, 3, wd);
        for (int i = 0; i < 4; i++) send_ifm(rand_ifm(), i == 3);
        send_ifm(rand_ifm(), 1'b0);
        check_eq("last_next_set", bus.op_weight, wd);
        send_ifm(rand_ifm(), 1'b1);
        bus.ifm_data = rand_ifm();
        bus.ifm_last = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("last_no_set_ready", bus.ifm_ready, 1'b0);
        end
        load_w(MODE_CONV3, 1, we);
        #1;
        check_eq("bubble_ready", bus.ifm_ready, 1'b1);
        @(negedge clk);
        check_eq("bubble_weight", bus.op_weight, we);
        idle(2);

        // backpressure for 5 cycles mid-stream
        load_w(MODE_CONV3, 20, rand_w());
        for (int i = 0; i < 3; i++) send_ifm(rand_ifm(), 1'b0);
        bus.op_ready = 1'b0;
        bus.ifm_data = rand_ifm();
        snap_ifm = bus.op_ifm;
        snap_w   = bus.op_weight;
        repeat (5) begin
            @(negedge clk);
            #1;
            check_eq("stall_ifm",    bus.op_ifm,    snap_ifm);
            check_eq("stall_weight", bus.op_weight, snap_w);
            check_eq("stall_ready",  bus.ifm_ready, 1'b0);
        end
        bus.op_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_ifm(rand_ifm(), i == 2);
        idle(2);

        // cfg_reuse = 0 behaves as 1
        wc = rand_w();
        wd = rand_w();
        load_w(MODE_CONV3, 0, wc);
        load_w(MODE_CONV3, 0, wd);
        send_ifm(rand_ifm(), 1'b0);
        check_eq("reuse0_first", bus.op_weight, wc);
        send_ifm(rand_ifm(), 1'b0);
        check_eq("reuse0_second", bus.op_weight, wd);
        check_eq("reuse0_empty", bus.act_valid, 1'b0);
        idle(2);

        // reset mid-stream with both valids high
        load_w(MODE_CONV3, 5, rand_w());
        send_ifm(rand_ifm(), 1'b0);
        bus.w_valid = 1'b1;
        bus.w_data  = rand_w();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rstm_op_valid",  bus.op_valid,  1'b0);
            check_eq("rstm_op_ifm",    bus.op_ifm,    '0);
            check_eq("rstm_op_weight", bus.op_weight, '0);
            check_eq("rstm_w_ready",   bus.w_ready,   1'b0);
            check_eq("rstm_ifm_ready", bus.ifm_ready, 1'b0);
            check_eq("rstm_act",       bus.act_valid, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_op_valid", bus.op_valid, 1'b0);
        check_eq("post_rst_op_ifm",   bus.op_ifm,   '0);
        idle(3);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            bus.w_valid   = ($urandom_range(0, 2) == 0);
            bus.w_data    = rand_w();
            bus.cfg_mode  = 1'($urandom_range(0, 1));
            bus.cfg_reuse = RW'($urandom_range(0, 3));
            bus.ifm_valid = ($urandom_range(0, 3) != 0);
            bus.ifm_data  = rand_ifm();
            bus.ifm_last  = ($urandom_range(0, 7) == 0);
            bus.op_ready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        bus.op_ready = 1'b1;
        idle(5);
        check_eq("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
